axi_dma_mm2s_connector: RTL and testbench

Forwards the AXI DMA MM2S output stream into the fabric one packet at a time. After a packet's TLAST is accepted, the input is held off until the DMA signals completion with a falling edge on AXIDMA_MM2S_INTR_IN. Provides per-packet beat accounting and TKEEP checking. Sits between the DMA MM2S master port and downstream fabric consumers, as the read-side counterpart of the S2MM connector.

---
 rtl/axi_dma_mm2s_connector_pkg.sv | 11 +
 rtl/axi_dma_mm2s_connector_axis_skid_buffer.sv | 67 ++++++
 rtl/axi_dma_mm2s_connector.sv | 164 ++++++++++++++++
 tb/tb_axi_dma_mm2s_connector.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_mm2s_connector_pkg.sv
// Shared definitions for the AXI DMA MM2S connector: input FSM state encoding.
package axi_dma_mm2s_connector_pkg;

    // Input-side packet FSM states, same encoding as the S2MM connector.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_HOLD   = 2'd2
    } dma_state_e;

endpackage

// File: rtl/axi_dma_mm2s_connector_axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer with a registered output stage.
// Input ready depends only on the skid register, so the downstream ready
// never reaches the upstream ready combinationally.
module axis_skid_buffer #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic                 out_vld_q, out_vld_d;
    logic [PAYLOAD_W-1:0] out_pld_q, out_pld_d;
    logic                 skid_vld_q, skid_vld_d;
    logic [PAYLOAD_W-1:0] skid_pld_q, skid_pld_d;
    logic                 in_acc;

    assign in_ready    = !skid_vld_q;
    assign in_acc      = in_valid && in_ready;
    assign out_valid   = out_vld_q;
    assign out_payload = out_pld_q;

    // Refill the output stage from the skid entry first, then from the input;
    // park an incoming beat in the skid entry while the output is stalled.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_pld_d  = out_pld_q;
        skid_vld_d = skid_vld_q;
        skid_pld_d = skid_pld_q;
        if (!out_vld_q || out_ready) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_pld_d  = skid_pld_q;
                skid_vld_d = 1'b0;
            end else if (in_acc) begin
                out_vld_d = 1'b1;
                out_pld_d = in_payload;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (in_acc) begin
            skid_vld_d = 1'b1;
            skid_pld_d = in_payload;
        end
    end

    // Buffer registers; reset empties both entries and zeroes the output payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_pld_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_pld_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_pld_q  <= out_pld_d;
            skid_vld_q <= skid_vld_d;
            skid_pld_q <= skid_pld_d;
        end
    end

endmodule

// File: rtl/axi_dma_mm2s_connector.sv
// AXI DMA MM2S connector: passes one packet at a time from the DMA read
// stream to the fabric, then holds the input off until the DMA interrupt
// falls. Also reports per-packet beat counts and flags malformed TKEEP.
module axi_dma_mm2s_connector
    import axi_dma_mm2s_connector_pkg::*;
#(
    parameter int TDATA_WIDTH    = 128,
    parameter int BEAT_CNT_WIDTH = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [TDATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic                      S_AXIS_TVALID,
    input  logic                      S_AXIS_TLAST,
    input  logic [TDATA_WIDTH/8-1:0]  S_AXIS_TKEEP,
    output logic                      S_AXIS_TREADY,
    output logic [TDATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic                      M_AXIS_TVALID,
    output logic                      M_AXIS_TLAST,
    output logic [TDATA_WIDTH/8-1:0]  M_AXIS_TKEEP,
    input  logic                      M_AXIS_TREADY,
    input  logic                      AXIDMA_MM2S_INTR_IN,
    output logic [BEAT_CNT_WIDTH-1:0] PKT_BEAT_COUNT,
    output logic                      PKT_DONE,
    output logic                      KEEP_ERR
);

    localparam int KEEP_W = TDATA_WIDTH / 8;
    localparam int PLD_W  = TDATA_WIDTH + KEEP_W + 1;
    localparam logic [KEEP_W-1:0]         KEEP_ALL = {KEEP_W{1'b1}};
    localparam logic [KEEP_W-1:0]         KEEP_ONE = {{(KEEP_W-1){1'b0}}, 1'b1};
    localparam logic [BEAT_CNT_WIDTH-1:0] CNT_MAX  = {BEAT_CNT_WIDTH{1'b1}};
    localparam logic [BEAT_CNT_WIDTH-1:0] CNT_ONE  = {{(BEAT_CNT_WIDTH-1){1'b0}}, 1'b1};

    dma_state_e                state_q, state_d;
    logic                      intr_q, intr_d;
    logic                      arm_q, arm_d;
    logic [BEAT_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [BEAT_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                      done_q, done_d;
    logic                      kerr_q, kerr_d;

    logic                      buf_in_ready;
    logic                      acc;
    logic                      intr_negedge;
    logic [PLD_W-1:0]          in_pld;
    logic [PLD_W-1:0]          out_pld;

    function automatic logic [BEAT_CNT_WIDTH-1:0] sat_inc(input logic [BEAT_CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Every beat before the last must carry a full word.
    function automatic logic keep_bad_mid(input logic [KEEP_W-1:0] k);
        return k != KEEP_ALL;
    endfunction

    // The last beat must be a non-empty run of ones starting at byte 0;
    // adding one to such a run clears every set bit.
    function automatic logic keep_bad_last(input logic [KEEP_W-1:0] k);
        return (k == '0) || ((k & (k + KEEP_ONE)) != '0);
    endfunction

    // arm_q keeps the input closed during reset and for the first cycle after it.
    assign S_AXIS_TREADY = arm_q && (state_q != ST_HOLD) && buf_in_ready;
    assign acc           = S_AXIS_TVALID && S_AXIS_TREADY;
    assign intr_negedge  = !AXIDMA_MM2S_INTR_IN && intr_q;
    assign in_pld        = {S_AXIS_TLAST, S_AXIS_TKEEP, S_AXIS_TDATA};

    assign {M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA} = out_pld;
    assign PKT_BEAT_COUNT = pkt_cnt_q;
    assign PKT_DONE       = done_q;
    assign KEEP_ERR       = kerr_q;

    axis_skid_buffer #(
        .PAYLOAD_W (PLD_W)
    ) u_skid (
        .clk         (ACLK),
        .rst         (ARESET),
        .in_payload  (in_pld),
        .in_valid    (acc),
        .in_ready    (buf_in_ready),
        .out_payload (out_pld),
        .out_valid   (M_AXIS_TVALID),
        .out_ready   (M_AXIS_TREADY)
    );

    // Packet FSM next state; an accepted TLAST outranks a same-cycle interrupt edge.
    always_comb begin
        state_d = state_q;
        intr_d  = AXIDMA_MM2S_INTR_IN;
        arm_d   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    state_d = S_AXIS_TLAST ? ST_HOLD : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (acc && S_AXIS_TLAST) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (intr_negedge) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, interrupt delay tap and post-reset arming flag.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            intr_q  <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            intr_q  <= intr_d;
            arm_q   <= arm_d;
        end
    end

    // Beat counting, completion pulse and sticky TKEEP checking on accepted beats.
    always_comb begin
        cnt_d     = cnt_q;
        pkt_cnt_d = pkt_cnt_q;
        done_d    = 1'b0;
        kerr_d    = kerr_q;
        if (acc) begin
            if (S_AXIS_TLAST) begin
                pkt_cnt_d = sat_inc(cnt_q);
                cnt_d     = '0;
                done_d    = 1'b1;
                if (keep_bad_last(S_AXIS_TKEEP)) begin
                    kerr_d = 1'b1;
                end
            end else begin
                cnt_d = sat_inc(cnt_q);
                if (keep_bad_mid(S_AXIS_TKEEP)) begin
                    kerr_d = 1'b1;
                end
            end
        end
    end

    // Counter and status registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt_q     <= '0;
            pkt_cnt_q <= '0;
            done_q    <= 1'b0;
            kerr_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
            done_q    <= done_d;
            kerr_q    <= kerr_d;
        end
    end

endmodule

// File: tb/tb_axi_dma_mm2s_connector.sv
// Self-checking bench for axi_dma_mm2s_connector: directed scenarios followed
// by randomized packets, all compared against a queue-based reference model.
module tb_axi_dma_mm2s_connector;

    localparam int DW = 128;
    localparam int KW = 16;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          ARESET;
    logic [DW-1:0] S_AXIS_TDATA;
    logic          S_AXIS_TVALID;
    logic          S_AXIS_TLAST;
    logic [KW-1:0] S_AXIS_TKEEP;
    logic          S_AXIS_TREADY;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TLAST;
    logic [KW-1:0] M_AXIS_TKEEP;
    logic          M_AXIS_TREADY;
    logic          INTR;
    logic [CW-1:0] PKT_BEAT_COUNT;
    logic          PKT_DONE;
    logic          KEEP_ERR;

    axi_dma_mm2s_connector #(
        .TDATA_WIDTH    (DW),
        .BEAT_CNT_WIDTH (CW)
    ) dut (
        .ACLK                (clk),
        .ARESET              (ARESET),
        .S_AXIS_TDATA        (S_AXIS_TDATA),
        .S_AXIS_TVALID       (S_AXIS_TVALID),
        .S_AXIS_TLAST        (S_AXIS_TLAST),
        .S_AXIS_TKEEP        (S_AXIS_TKEEP),
        .S_AXIS_TREADY       (S_AXIS_TREADY),
        .M_AXIS_TDATA        (M_AXIS_TDATA),
        .M_AXIS_TVALID       (M_AXIS_TVALID),
        .M_AXIS_TLAST        (M_AXIS_TLAST),
        .M_AXIS_TKEEP        (M_AXIS_TKEEP),
        .M_AXIS_TREADY       (M_AXIS_TREADY),
        .AXIDMA_MM2S_INTR_IN (INTR),
        .PKT_BEAT_COUNT      (PKT_BEAT_COUNT),
        .PKT_DONE            (PKT_DONE),
        .KEEP_ERR            (KEEP_ERR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    // Reference model: beats accepted but not yet delivered, plus packet status.
    beat_t         exp_q[$];
    bit            m_closed;
    bit            m_armed;
    bit            m_kerr;
    bit            m_done;
    bit            m_intr_prev;
    int            m_cnt;
    logic [CW-1:0] m_pkt;

    int n_cmp;
    int n_err;
    int done_seen;
    int rdy_mode;   // 0 high, 1 toggle, 2 random, 3 low
    bit intr_rand;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // A legal last-beat TKEEP is 2^n - 1 for some n >= 1.
    function automatic bit keep_prefix(input logic [KW-1:0] k);
        int n;
        n = 0;
        for (int i = 0; i < KW; i++) if (k[i]) n++;
        return (n > 0) && (k == KW'((33'd1 << n) - 33'd1));
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_closed    = 1'b0;
        m_armed     = 1'b0;
        m_kerr      = 1'b0;
        m_done      = 1'b0;
        m_intr_prev = 1'b0;
        m_cnt       = 0;
        m_pkt       = '0;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model across the edge.
    task automatic step(output bit acc);
        bit    take;
        bit    intr_now;
        beat_t b;
        case (rdy_mode)
            1:       M_AXIS_TREADY = ~M_AXIS_TREADY;
            2:       M_AXIS_TREADY = 1'($urandom_range(0, 1));
            3:       M_AXIS_TREADY = 1'b0;
            default: M_AXIS_TREADY = 1'b1;
        endcase
        if (intr_rand && ($urandom_range(0, 5) == 0)) INTR = ~INTR;
        @(negedge clk);
        if (ARESET) model_reset();
        chk("s_tready", 128'(S_AXIS_TREADY), 128'(m_armed && !m_closed && (exp_q.size() < 2)));
        chk("m_tvalid", 128'(M_AXIS_TVALID), 128'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("m_tdata", 128'(M_AXIS_TDATA), 128'(exp_q[0].d));
            chk("m_tkeep", 128'(M_AXIS_TKEEP), 128'(exp_q[0].k));
            chk("m_tlast", 128'(M_AXIS_TLAST), 128'(exp_q[0].l));
        end else if (ARESET) begin
            chk("rst_tdata", 128'(M_AXIS_TDATA), 128'(0));
            chk("rst_tkeep", 128'(M_AXIS_TKEEP), 128'(0));
            chk("rst_tlast", 128'(M_AXIS_TLAST), 128'(0));
        end
        chk("pkt_beat_count", 128'(PKT_BEAT_COUNT), 128'(m_pkt));
        chk("pkt_done", 128'(PKT_DONE), 128'(m_done));
        chk("keep_err", 128'(KEEP_ERR), 128'(m_kerr));
        if (PKT_DONE) done_seen++;
        acc      = S_AXIS_TVALID && S_AXIS_TREADY;
        take     = M_AXIS_TVALID && M_AXIS_TREADY;
        intr_now = INTR;
        b        = '{d: S_AXIS_TDATA, k: S_AXIS_TKEEP, l: S_AXIS_TLAST};
        @(posedge clk);
        if (ARESET) begin
            model_reset();
        end else begin
            m_armed = 1'b1;
            m_done  = 1'b0;
            if (take && (exp_q.size() != 0)) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(b);
                if (b.l) begin
                    m_pkt    = CW'(sat(m_cnt + 1));
                    m_cnt    = 0;
                    m_done   = 1'b1;
                    m_closed = 1'b1;
                    if (!keep_prefix(b.k)) m_kerr = 1'b1;
                end else begin
                    m_cnt = sat(m_cnt + 1);
                    if (b.k != {KW{1'b1}}) m_kerr = 1'b1;
                end
            end else if (m_closed && m_intr_prev && !intr_now) begin
                m_closed = 1'b0;
            end
            m_intr_prev = intr_now;
        end
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        S_AXIS_TVALID = 1'b0;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic send_pkt(input int len, input int stop_after, input logic [KW-1:0] mid_keep,
                            input logic [KW-1:0] last_keep, input bit gaps, input bit drop_intr_on_last);
        bit a;
        int guard;
        for (int i = 0; i < len && i < stop_after; i++) begin
            S_AXIS_TDATA = {$urandom, $urandom, $urandom, $urandom};
            S_AXIS_TKEEP = (i == len - 1) ? last_keep : mid_keep;
            S_AXIS_TLAST = (i == len - 1);
            if ((i == len - 1) && drop_intr_on_last) INTR = 1'b0;
            guard = 0;
            a = 1'b0;
            while (!a) begin
                S_AXIS_TVALID = !(gaps && ($urandom_range(0, 3) == 0));
                step(a);
                guard++;
                if (!a && guard > 300) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL send_timeout: observed no accept, expected accept within 300 cycles");
                    S_AXIS_TVALID = 1'b0;
                    return;
                end
            end
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic release_hold();
        INTR = 1'b1;
        idle(1);
        INTR = 1'b0;
        idle(1);
    endtask

    task automatic do_reset(input int n);
        ARESET = 1'b1;
        idle(n);
        ARESET = 1'b0;
        idle(1);
    endtask

    initial begin
        bit            a;
        logic [KW-1:0] lk;
        logic [KW-1:0] mk;
        n_cmp = 0; n_err = 0; done_seen = 0;
        rdy_mode = 0; intr_rand = 1'b0;
        ARESET = 1'b1; INTR = 1'b0; M_AXIS_TREADY = 1'b1;
        S_AXIS_TDATA = '0; S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0; S_AXIS_TKEEP = '0;
        model_reset();

        // Reset values, then a 4-beat full-throughput packet.
        idle(3);
        ARESET = 1'b0;
        idle(2);
        done_seen = 0;
        send_pkt(4, 99, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        idle(3);
        chk("t1_pkt_count", 128'(PKT_BEAT_COUNT), 128'(4));
        chk("t1_done_pulses", 128'(done_seen), 128'(1));

        // Second packet blocked until the interrupt falls.
        S_AXIS_TDATA = {$urandom, $urandom, $urandom, $urandom};
        S_AXIS_TKEEP = 16'hFFFF; S_AXIS_TLAST = 1'b0; S_AXIS_TVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(a);
            chk("t2_blocked", 128'(a), 128'(0));
        end
        INTR = 1'b1; step(a);
        chk("t2_still_held", 128'(S_AXIS_TREADY), 128'(0));
        INTR = 1'b0; step(a);
        chk("t2_rearm", 128'(S_AXIS_TREADY), 128'(1));
        send_pkt(3, 99, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        idle(3);
        chk("t2_pkt_count", 128'(PKT_BEAT_COUNT), 128'(3));
        release_hold();

        // Downstream stalls every other cycle over 8 beats.
        rdy_mode = 1;
        send_pkt(8, 99, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        rdy_mode = 0;
        idle(4);
        chk("t3_pkt_count", 128'(PKT_BEAT_COUNT), 128'(8));
        release_hold();

        // TKEEP checking.
        do_reset(2);
        send_pkt(2, 99, 16'hFFFF, 16'h00FF, 1'b0, 1'b0);
        idle(2);
        chk("t4_partial_last_ok", 128'(KEEP_ERR), 128'(0));
        release_hold();
        send_pkt(3, 99, 16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
        idle(2);
        chk("t4_mid_keep_err", 128'(KEEP_ERR), 128'(1));
        release_hold();
        send_pkt(2, 99, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        idle(3);
        chk("t4_sticky", 128'(KEEP_ERR), 128'(1));
        do_reset(2);
        chk("t4_cleared", 128'(KEEP_ERR), 128'(0));
        send_pkt(2, 99, 16'hFFFF, 16'h0F0F, 1'b0, 1'b0);
        idle(2);
        chk("t4_last_gap_err", 128'(KEEP_ERR), 128'(1));
        release_hold();

        // TLAST accepted in the same cycle as an interrupt falling edge.
        INTR = 1'b1;
        idle(2);
        send_pkt(3, 99, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        idle(4);
        chk("t5_hold_after_tie", 128'(S_AXIS_TREADY), 128'(0));
        release_hold();
        chk("t5_rearm", 128'(S_AXIS_TREADY), 128'(1));
        send_pkt(1, 99, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle(2);
        chk("t5_single_beat", 128'(PKT_BEAT_COUNT), 128'(1));
        release_hold();

        // Reset in the middle of a buffered packet.
        rdy_mode = 3;
        send_pkt(5, 2, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        ARESET = 1'b1;
        idle(1);
        chk("t6_rst_tvalid", 128'(M_AXIS_TVALID), 128'(0));
        chk("t6_rst_tready", 128'(S_AXIS_TREADY), 128'(0));
        ARESET = 1'b0;
        rdy_mode = 0;
        idle(2);
        send_pkt(3, 99, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        idle(3);
        chk("t6_fresh_count", 128'(PKT_BEAT_COUNT), 128'(3));
        release_hold();

        // Randomized packets, stalls, valid gaps and interrupt activity.
        rdy_mode = 2;
        intr_rand = 1'b1;
        for (int p = 0; p < 40; p++) begin
            mk = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'hFFFF;
            case ($urandom_range(0, 3))
                0:       lk = 16'hFFFF;
                1:       lk = 16'h00FF;
                2:       lk = 16'h0001;
                default: lk = 16'($urandom);
            endcase
            send_pkt($urandom_range(1, 20), 99, mk, lk, 1'b1, 1'b0);
        end
        intr_rand = 1'b0;
        rdy_mode = 0;
        idle(10);
        chk("final_drained", 128'(M_AXIS_TVALID), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
